// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the round-robin APB arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic [IDX_W-1:0] cand_s;

    // Scan from last_grant+1 around to last_grant itself; the first hit wins.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        cand_s    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!any_valid && req[cand_s]) begin
                grant_idx = cand_s;
                any_valid = 1'b1;
            end else begin
                grant_idx = grant_idx;
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter of NUM_REQ command ports onto one APB master.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
    output logic                               rsp_err,
    output logic                               psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [APB_ADDR_WIDTH-1:0]          paddr,
    output logic [APB_DATA_WIDTH-1:0]          pwdata,
    input  logic [APB_DATA_WIDTH-1:0]          prdata,
    input  logic                               pready,
    input  logic                               pslverr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e                  state_q, state_d;
    logic [IDX_W-1:0]            last_grant_q, last_grant_d;
    logic                        pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic [IDX_W-1:0]            pick_idx_s;
    logic                        pick_any_s;
    logic [APB_ADDR_WIDTH-1:0]   addr_arr_s  [NUM_REQ];
    logic [APB_DATA_WIDTH-1:0]   wdata_arr_s [NUM_REQ];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit_s;
    assign tmo_hit_s = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr_s[g]  = req_addr[g*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        assign wdata_arr_s[g] = req_wdata[g*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant_idx  (pick_idx_s),
        .any_valid  (pick_any_s)
    );

    // State and datapath registers; last_grant resets so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) state_d = ST_SETUP;
                else            state_d = ST_IDLE;
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready)         state_d = ST_RESP;
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_hit_s) state_d = ST_RESP;
`endif
                else                state_d = ST_ACCESS;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture at grant, response capture at the end of ACCESS.
    always_comb begin
        last_grant_d = last_grant_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    last_grant_d = pick_idx_s;
                    pwrite_d     = req_write[pick_idx_s];
                    paddr_d      = addr_arr_s[pick_idx_s];
                    pwdata_d     = wdata_arr_s[pick_idx_s];
                end else begin
                    last_grant_d = last_grant_q;
                end
            end
            ST_SETUP: begin
                rdata_d   = '0;
                err_d     = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = pslverr;
`ifdef APB_ARB_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`else
                end else begin
                    rdata_d = rdata_q;
                end
`endif
            end
            ST_RESP: rdata_d = rdata_q;
            default: rdata_d = rdata_q;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) req_ready[pick_idx_s] = 1'b1;
                else            req_ready = '0;
            end
            ST_SETUP:  psel = 1'b1;
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            ST_RESP: begin
                rsp_valid[last_grant_q] = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: psel = 1'b0;
        endcase
    end

    assign pwrite = pwrite_q;
    assign paddr  = paddr_q;
    assign pwdata = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter (NUM_REQ=4, 12-bit address).
module tb_apb_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = 4'b0;
    logic [3:0]   req_ready;
    logic [3:0]   req_write = 4'b0;
    logic [47:0]  req_addr = 48'b0;
    logic [127:0] req_wdata = 128'b0;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         psel, penable, pwrite;
    logic [11:0]  paddr;
    logic [31:0]  pwdata;
    logic [31:0]  prdata = 32'b0;
    logic         pready = 1'b0;
    logic         pslverr = 1'b0;

    int total = 0;
    int bad   = 0;

    apb_rr_arbiter #(
        .NUM_REQ        (4),
        .APB_ADDR_WIDTH (12),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic w, input logic [11:0] a, input logic [31:0] d);
        req_write[i]         = w;
        req_addr[i*12 +: 12] = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {psel, penable, pwrite}); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        total++; if ({rsp_err, rsp_rdata, paddr, pwdata} !== 77'b0) begin bad++; $display("FAIL reset_data: err=%b rdata=%h paddr=%h pwdata=%h want all 0", rsp_err, rsp_rdata, paddr, pwdata); end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        @(negedge clk);
        set_req(2, 1'b0, 12'h010, 32'h0);
        req_valid = 4'b0100; prdata = 32'hDEADBEEF; pready = 1'b1; pslverr = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL read_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        total++; if ({psel, penable, pwrite, paddr} !== {3'b100, 12'h010}) begin bad++; $display("FAIL read_setup: psel/pen/pwr=%b paddr=%h want 100/010", {psel, penable, pwrite}, paddr); end
        @(negedge clk);
        total++; if ({psel, penable, rsp_valid} !== 6'b110000) begin bad++; $display("FAIL read_access: psel/pen=%b rsp_valid=%b want 11/0000", {psel, penable}, rsp_valid); end
        @(negedge clk);
        total++; if ({rsp_valid, psel, penable} !== 6'b010000) begin bad++; $display("FAIL read_resp_valid: rsp_valid=%b psel/pen=%b want 0100/00", rsp_valid, {psel, penable}); end
        total++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL read_resp_data: err=%b rdata=%h want 0/deadbeef", rsp_err, rsp_rdata); end
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL read_resp_len: got %b want 0000", rsp_valid); end
        pready = 1'b0;
    endtask

    task automatic test_rr_order;
        logic [3:0]  exp_oh;
        logic [31:0] exp_wd;
        int          exp;
        int          w;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 12'h100 + 12'(i * 4), 32'hA5A5_0000 + 32'(i));
        req_valid = 4'b1111; pready = 1'b1; pslverr = 1'b0;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp    = g % 4;
            exp_oh = 4'b0001 << exp;
            exp_wd = 32'hA5A5_0000 + 32'(exp);
            w      = 0;
            while (req_ready === 4'b0000 && w < 10) begin
                @(negedge clk);
                w++;
            end
            total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_oh); end
            @(negedge clk);
            total++; if ({pwrite, pwdata} !== {1'b1, exp_wd}) begin bad++; $display("FAIL rr_pwdata%0d: pwrite=%b pwdata=%h want 1/%h", g, pwrite, pwdata, exp_wd); end
        end
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        pready = 1'b0;
    endtask

    task automatic test_write_wait_err;
        @(negedge clk);
        set_req(1, 1'b1, 12'h0AB, 32'hCAFEF00D);
        req_valid = 4'b0010; pready = 1'b0; pslverr = 1'b1; prdata = 32'h12345678;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wr_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        total++; if ({psel, penable} !== 2'b10) begin bad++; $display("FAIL wr_setup: got %b want 10", {psel, penable}); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++; if ({psel, penable, pwrite, paddr, pwdata} !== {3'b111, 12'h0AB, 32'hCAFEF00D}) begin bad++; $display("FAIL wr_access%0d: ctrl=%b paddr=%h pwdata=%h want 111/0ab/cafef00d", k, {psel, penable, pwrite}, paddr, pwdata); end
            if (k == 6) pready = 1'b1;
        end
        @(negedge clk);
        total++; if ({rsp_valid, psel, penable} !== 6'b001000) begin bad++; $display("FAIL wr_resp_valid: rsp_valid=%b psel/pen=%b want 0010/00", rsp_valid, {psel, penable}); end
        total++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL wr_resp_err: err=%b rdata=%h want 1/00000000", rsp_err, rsp_rdata); end
        pready = 1'b0; pslverr = 1'b0;
        @(negedge clk);
        total++; if ({psel, penable, paddr, pwdata} !== {2'b00, 12'h0AB, 32'hCAFEF00D}) begin bad++; $display("FAIL wr_hold: psel/pen=%b paddr=%h pwdata=%h want 00/0ab/cafef00d", {psel, penable}, paddr, pwdata); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_req(2, 1'b0, 12'h3C0, 32'h0);
        req_valid = 4'b0100; pready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rst_mid_grant: got %b want 0100", req_ready); end
        @(negedge clk); req_valid = 4'b0000;
        @(negedge clk);
        total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL rst_mid_access: got %b want 11", {psel, penable}); end
        #2 rst = 1'b1;
        #1;
        total++; if ({psel, penable, rsp_valid} !== 6'b000000) begin bad++; $display("FAIL rst_mid_async: psel/pen=%b rsp_valid=%b want 00/0000", {psel, penable}, rsp_valid); end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if ({psel, rsp_valid} !== 5'b00000) begin bad++; $display("FAIL rst_mid_quiet%0d: psel=%b rsp_valid=%b want 0/0000", k, psel, rsp_valid); end
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 12'h200 + 12'(i), 32'h0);
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_mid_priority: got %b want 0001", req_ready); end
        pready = 1'b1;
        @(negedge clk); req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        pready = 1'b0;
    endtask

    task automatic test_timeout;
        @(negedge clk);
        set_req(0, 1'b0, 12'h7FF, 32'h0);
        req_valid = 4'b0001; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BADF00D;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL tmo_grant: got %b want 0001", req_ready); end
        @(negedge clk); req_valid = 4'b0000;
`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++; if ({psel, penable, rsp_valid} !== 6'b110000) begin bad++; $display("FAIL tmo_wait%0d: psel/pen=%b rsp_valid=%b want 11/0000", k, {psel, penable}, rsp_valid); end
        end
        @(negedge clk);
        total++; if ({rsp_valid, psel, penable} !== 6'b000100) begin bad++; $display("FAIL tmo_resp: rsp_valid=%b psel/pen=%b want 0001/00", rsp_valid, {psel, penable}); end
        total++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL tmo_err: err=%b rdata=%h want 1/00000000", rsp_err, rsp_rdata); end
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            total++; if ({psel, penable, rsp_valid} !== 6'b110000) begin bad++; $display("FAIL pend_wait%0d: psel/pen=%b rsp_valid=%b want 11/0000", k, {psel, penable}, rsp_valid); end
        end
        pready = 1'b1;
        @(negedge clk);
        pready = 1'b0;
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b0, 32'h0BADF00D}) begin bad++; $display("FAIL pend_resp: rsp_valid=%b err=%b rdata=%h want 0001/0/0badf00d", rsp_valid, rsp_err, rsp_rdata); end
`endif
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL tmo_idle: got %b want 0000", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_order();
        test_write_wait_err();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, ACCESS-phase cycle limit (used only with APB_ARB_TIMEOUT_EN).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester command valid; held until accepted.
REQ-008 req_ready  out  NUM_REQ  per-requester accept pulse, one-hot or zero.
REQ-009 req_write  in  NUM_REQ  per-requester direction (1 = write).
REQ-010 req_addr  in  NUM_REQ x APB_ADDR_WIDTH  per-requester address.
REQ-011 req_wdata  in  NUM_REQ x 32  per-requester write data.
REQ-012 rsp_valid  out  NUM_REQ  per-requester completion pulse, one-hot or zero.
REQ-013 rsp_rdata  out  32  read data, shared, valid with rsp_valid.
REQ-014 rsp_err  out  1  error flag, shared, valid with rsp_valid.
REQ-015 psel, penable, pwrite  out  1 each  APB control.
REQ-016 paddr  out  APB_ADDR_WIDTH; pwdata  out  32  APB address and write data.
REQ-017 prdata  in  32; pready, pslverr  in  1 each  APB slave response.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-019 In IDLE with any req_valid set, the block SHALL grant the first set requester in round-robin order, starting at last_grant+1 and wrapping modulo NUM_REQ.
REQ-020 In the grant cycle, req_ready[g] SHALL be 1 combinationally, and the cycle SHALL latch write/addr/wdata of requester g, update last_grant to g, and go to SETUP.
REQ-021 SETUP SHALL last exactly one cycle: psel=1, penable=0, then go to ACCESS.
REQ-022 ACCESS SHALL drive psel=1 and penable=1 until pready=1.
REQ-023 On the cycle pready=1 in ACCESS, the block SHALL register prdata (reads; 0 for writes) and pslverr, then go to RESP.
REQ-024 RESP SHALL last one cycle: rsp_valid[g]=1, rsp_rdata and rsp_err valid, psel=penable=0, then go to IDLE.
REQ-025 Minimum latency: grant at cycle T, rsp_valid at T+3; sustained throughput of one transfer per 4 cycles.
REQ-026 paddr, pwrite and pwdata SHALL be stable from SETUP through the end of ACCESS; outside SETUP/ACCESS they SHALL hold their last values.
REQ-027 A requester that deasserts req_valid before it is granted SHALL be ignored; the block SHALL NOT check for this protocol violation.
REQ-028 A new grant SHALL NOT occur outside IDLE; at most one transfer is outstanding.
REQ-029 With a single active requester, that requester SHALL be granted on every IDLE visit.

Reset
REQ-030 While rst=1: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has top priority), and all outputs 0, including psel, penable, req_ready, rsp_valid and rsp_err.
REQ-031 Reset asserted mid-transfer SHALL drop psel/penable asynchronously, and no rsp_valid SHALL be issued for the aborted transfer.

Configuration
REQ-032 Macro APB_ARB_TIMEOUT_EN, when defined, SHALL add a counter cleared on entry to ACCESS and incremented each ACCESS cycle with pready=0.
REQ-033 With APB_ARB_TIMEOUT_EN defined, after TIMEOUT_CYCLES such cycles the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0, deasserting psel/penable.
REQ-034 Without APB_ARB_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-035 The package apb_arb_pkg SHALL hold the FSM state enum typedef and the APB data width constant (32).
REQ-036 The combinational round-robin picker SHALL be the sub-module rr_arb_pick (inputs: request vector and last_grant; outputs: grant index and any_valid).

Verification
REQ-037 Single read: req_valid[2]=1, addr=0x010, prdata=0xDEADBEEF, pready at the first ACCESS cycle -> req_ready[2] at T, psel at T+1..T+2, penable at T+2, rsp_valid[2] at T+3 with rdata 0xDEADBEEF and err 0.
REQ-038 All four requesters valid continuously after reset -> grant order 0,1,2,3,0 and each pwdata matches its requester.
REQ-039 Write with pready delayed 5 cycles and pslverr=1 -> ACCESS lasts 6 cycles, paddr/pwdata stable throughout, rsp_err=1, rsp_rdata=0.
REQ-040 rst asserted during ACCESS -> psel=0 immediately, no rsp_valid, and after release requester 0 has priority.
REQ-041 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0 -> rsp_valid after 8 ACCESS cycles with rsp_err=1; without the macro, the transfer is still pending after 100 cycles.
